// File: rtl/pretrig_sequencer.sv
// Pre-trigger sequencer: issues a programmable train of seeds, delays each
// seed by DELAY cycles and stretches it into a trigger pulse of latched width.
module pretrig_sequencer #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8,
  parameter int DELAY = 6,
  parameter int PW_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] ntrig,
  input  logic [GAP_W-1:0] gap,
  input  logic [PW_W-1:0]  width,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, state_nx;

  logic               mode_l;
  logic [CNT_W-1:0]   ntrig_l;
  logic [GAP_W-1:0]   gap_l;
  logic [PW_W-1:0]    width_l;
  logic               stop_pend;

  logic [GAP_W-1:0]   gap_cnt;
  logic [PW_W-1:0]    pw_cnt;
  logic [DELAY-1:0]   dly;

  logic               seed;
  logic               arm;
  logic               halt;
  logic               last_seed;
  logic [CNT_W-1:0]   sent_inc;

  assign sent_inc  = sent_count + CNT_W'(1);
  // A stop that arrived together with start is held until the first RUN cycle.
  assign halt      = stop || stop_pend || !ena;
  assign last_seed = !mode_l && (sent_inc == ntrig_l);

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // Next-state logic plus seed and arm strobes
  always_comb begin
    state_nx = state;
    seed     = 1'b0;
    arm      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && ena) begin
          arm = 1'b1;
          if (!mode && ntrig == '0) state_nx = S_DONE;
          else                      state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_nx = S_DRAIN;
        end else if (gap_cnt == '0) begin
          seed = 1'b1;
          if (last_seed) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dly == '0 && !trigger) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Sequence configuration latch, seed spacing counter and seed count
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_l     <= 1'b0;
      ntrig_l    <= '0;
      gap_l      <= '0;
      width_l    <= '0;
      stop_pend  <= 1'b0;
      gap_cnt    <= '0;
      sent_count <= '0;
    end else if (arm) begin
      mode_l     <= mode;
      ntrig_l    <= ntrig;
      gap_l      <= gap;
      width_l    <= width;
      stop_pend  <= stop;
      gap_cnt    <= '0;
      sent_count <= '0;
    end else begin
      if (state == S_RUN) stop_pend <= 1'b0;
      if (seed) begin
        sent_count <= sent_inc;
        gap_cnt    <= gap_l;
      end else if (state == S_RUN && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Seed delay line
  always_ff @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= (dly << 1) | DELAY'(seed);
  end

  // Pulse stretcher; a new arrival reloads the count so overlapping pulses merge
  always_ff @(posedge clk) begin
    if (rst) begin
      trigger <= 1'b0;
      pw_cnt  <= '0;
    end else if (dly[DELAY-1]) begin
      trigger <= 1'b1;
      pw_cnt  <= (width_l == '0) ? '0 : width_l - PW_W'(1);
    end else if (trigger) begin
      if (pw_cnt == '0) trigger <= 1'b0;
      else              pw_cnt  <= pw_cnt - PW_W'(1);
    end
  end

endmodule

// File: tb/tb_pretrig_sequencer.sv
// Randomised and directed bench for pretrig_sequencer against a time-based
// reference model (seed times -> pulse intervals).
module tb_pretrig_sequencer;

  localparam int CNT_W = 4;
  localparam int GAP_W = 8;
  localparam int DELAY = 6;
  localparam int PW_W  = 4;

  logic             clk = 1'b0;
  logic             rst, ena, start, stop, mode;
  logic [CNT_W-1:0] ntrig;
  logic [GAP_W-1:0] gap;
  logic [PW_W-1:0]  width;
  logic             trigger, busy, done;
  logic [CNT_W-1:0] sent_count;

  pretrig_sequencer #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W),
    .DELAY(DELAY),
    .PW_W (PW_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .ntrig     (ntrig),
    .gap       (gap),
    .width     (width),
    .trigger   (trigger),
    .busy      (busy),
    .done      (done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a phase plus the list of pulse intervals [lo,hi]
  // derived from seed times (lo = seed+DELAY+1, hi = seed+DELAY+width).
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_sent = 0, m_next = 0, m_ntrig = 0, m_gap = 0, m_w = 1;
  bit      m_mode = 0, m_stop_pend = 0;
  int      p_lo[$], p_hi[$];

  int cyc = 0;
  bit chk_en = 0;

  int trig_hi, first_hi, last_hi, done_cnt, done_at, busy_seen;

  function automatic bit exp_trig(input int c);
    foreach (p_lo[i]) if (p_lo[i] <= c && c <= p_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int last_end();
    int m = -1;
    foreach (p_hi[i]) if (p_hi[i] > m) m = p_hi[i];
    return m;
  endfunction

  task automatic model_step(input int c);
    if (rst) begin
      m_phase = M_IDLE; m_sent = 0; m_stop_pend = 0;
      p_lo.delete(); p_hi.delete();
    end else begin
      case (m_phase)
        M_IDLE: if (start && ena) begin
          m_mode  = mode;
          m_ntrig = int'(ntrig);
          m_gap   = int'(gap);
          m_w     = (width == '0) ? 1 : int'(width);
          m_sent  = 0;
          p_lo.delete(); p_hi.delete();
          if (!mode && ntrig == '0) m_phase = M_DONE;
          else begin
            m_phase = M_RUN; m_next = c + 1; m_stop_pend = stop;
          end
        end
        M_RUN: begin
          if (stop || m_stop_pend || !ena) m_phase = M_DRAIN;
          else if (c == m_next) begin
            p_lo.push_back(c + DELAY + 1);
            p_hi.push_back(c + DELAY + m_w);
            m_sent = (m_sent + 1) % (1 << CNT_W);
            m_next = c + m_gap + 1;
            if (!m_mode && m_sent == m_ntrig) m_phase = M_DRAIN;
          end
          m_stop_pend = 0;
        end
        M_DRAIN: if (last_end() < c) m_phase = M_DONE;
        M_DONE:  m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  task automatic clr_meas();
    trig_hi = 0; first_hi = -1; last_hi = -1; done_cnt = 0; done_at = -1; busy_seen = 0;
  endtask

  // Compare this cycle's outputs, advance the model with this cycle's inputs, step one clock.
  task automatic tick();
    if (chk_en) begin
      check("trigger", trigger, exp_trig(cyc));
      check("busy", busy, m_phase == M_RUN || m_phase == M_DRAIN);
      check("done", done, m_phase == M_DONE);
      check("sent_count", sent_count, m_sent);
      if (trigger === 1'b1) begin
        trig_hi++;
        if (first_hi < 0) first_hi = cyc;
        last_hi = cyc;
      end
      if (done === 1'b1) begin done_cnt++; done_at = cyc; end
      if (busy === 1'b1) busy_seen = 1;
    end
    model_step(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic arm(input bit md, input int nt, input int gp, input int wd, input bit stp,
                     output int t0);
    mode = md; ntrig = CNT_W'(nt); gap = GAP_W'(gp); width = PW_W'(wd);
    start = 1'b1; stop = stp; ena = 1'b1;
    t0 = cyc;
    clr_meas();
    tick();
    start = 1'b0; stop = 1'b0;
    mode  = ~md;
    ntrig = CNT_W'($urandom); gap = GAP_W'($urandom); width = PW_W'($urandom);
  endtask

  task automatic run_seq(input int t0, input int stop_at, input int ena_off, input int rst_at,
                         input bit noise, input int budget);
    for (int k = 0; k < budget && m_phase != M_IDLE; k++) begin
      int r;
      r     = cyc - t0;
      stop  = (r == stop_at) || (noise && $urandom_range(0, 15) == 0);
      ena   = !(ena_off > 0 && r >= ena_off && r < ena_off + 2);
      rst   = (r == rst_at);
      if (noise) begin
        start = 1'($urandom);
        mode  = 1'($urandom);
        ntrig = CNT_W'($urandom); gap = GAP_W'($urandom); width = PW_W'($urandom);
      end
      tick();
    end
    rst = 1'b0; stop = 1'b0; ena = 1'b1; start = 1'b0;
    check("seq_timeout", m_phase == M_IDLE, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; ena = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0;
    ntrig = 4'd3; gap = '0; width = 4'd1;
    clr_meas();
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();

    // Burst: ntrig=3, gap=9, width=3
    arm(1'b0, 3, 9, 3, 1'b0, t0);
    run_seq(t0, -1, -1, -1, 1'b0, 200);
    check("b3_first_hi", first_hi - t0, 8);
    check("b3_last_hi", last_hi - t0, 30);
    check("b3_hi_cycles", trig_hi, 9);
    check("b3_done_at", done_at - t0, 32);
    check("b3_done_cnt", done_cnt, 1);
    check("b3_sent", sent_count, 3);
    repeat (2) tick();

    // Burst with ntrig=0
    arm(1'b0, 0, 4, 2, 1'b0, t0);
    start = 1'b1;
    run_seq(t0, -1, -1, -1, 1'b0, 50);
    check("n0_done_at", done_at - t0, 1);
    check("n0_busy_seen", busy_seen, 0);
    check("n0_trig", trig_hi, 0);
    repeat (2) tick();

    // Continuous gap=1 width=4, stop at cycle 20
    arm(1'b1, 0, 1, 4, 1'b0, t0);
    run_seq(t0, 20, -1, -1, 1'b0, 200);
    check("c_first_hi", first_hi - t0, 8);
    check("c_last_hi", last_hi - t0, 29);
    check("c_hi_cycles", trig_hi, 22);
    check("c_done_at", done_at - t0, 31);
    check("c_sent", sent_count, 10);
    repeat (2) tick();

    // gap=0 width=0 ntrig=5
    arm(1'b0, 5, 0, 0, 1'b0, t0);
    run_seq(t0, -1, -1, -1, 1'b0, 200);
    check("g0_hi_cycles", trig_hi, 5);
    check("g0_span", last_hi - first_hi, 4);
    check("g0_first_hi", first_hi - t0, 8);
    check("g0_done_at", done_at - t0, 14);
    repeat (2) tick();

    // Reset while trigger is high
    arm(1'b1, 0, 2, 3, 1'b0, t0);
    while (cyc - t0 < 12) tick();
    check("pre_rst_trig", trigger, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_trig", trigger, 0);
    check("post_rst_busy", busy, 0);
    clr_meas();
    repeat (20) tick();
    check("post_rst_no_pulse", trig_hi, 0);

    // ena dropped during RUN
    arm(1'b0, 8, 3, 2, 1'b0, t0);
    run_seq(t0, -1, 6, -1, 1'b0, 200);
    check("ena_sent", sent_count, 2);
    check("ena_hi_cycles", trig_hi, 4);
    check("ena_done_cnt", done_cnt, 1);
    repeat (2) tick();

    // start and stop together
    arm(1'b0, 4, 0, 2, 1'b1, t0);
    run_seq(t0, -1, -1, -1, 1'b0, 100);
    check("ss_sent", sent_count, 0);
    check("ss_trig", trig_hi, 0);
    check("ss_done_at", done_at - t0, 3);
    repeat (2) tick();

    // Continuous sent_count wrap: 20 seeds on a 4-bit count
    arm(1'b1, 0, 0, 1, 1'b0, t0);
    run_seq(t0, 21, -1, -1, 1'b0, 200);
    check("wrap_sent", sent_count, 4);
    repeat (2) tick();

    // Randomised sequences with input noise, stops, enable drops and resets
    for (int it = 0; it < 40; it++) begin
      bit md;
      int stop_at, ena_off, rst_at;
      md      = 1'($urandom);
      stop_at = (md || $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : -1;
      ena_off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      rst_at  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 40)) : -1;
      arm(md, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 6)), 1'($urandom_range(0, 9) == 0), t0);
      run_seq(t0, stop_at, ena_off, rst_at, 1'b1, 400);
      repeat (int'($urandom_range(1, 3))) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pretrig_sequencer.md
PRETRIG_SEQUENCER -- requirements
Module: pretrig_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the trigger-count and sent-count fields.
REQ-002 SHALL have parameter GAP_W, default 8, meaning the width of the gap field.
REQ-003 SHALL have parameter DELAY, default 6 (legal range 1..64), meaning the fixed seed-to-trigger latency in cycles.
REQ-004 SHALL have parameter PW_W, default 4, meaning the width of the pulse-width field.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ena, input, 1 bit: global enable.
REQ-008 SHALL have port start, input, 1 bit: arm request, sampled only in IDLE.
REQ-009 SHALL have port stop, input, 1 bit: end a running sequence early.
REQ-010 SHALL have port mode, input, 1 bit: 0 = burst of ntrig seeds, 1 = continuous.
REQ-011 SHALL have port ntrig, input, CNT_W bits: number of triggers in burst mode.
REQ-012 SHALL have port gap, input, GAP_W bits: seed spacing, in cycles, minus one.
REQ-013 SHALL have port width, input, PW_W bits: trigger pulse width in cycles; 0 is treated as 1.
REQ-014 SHALL have port trigger, output, 1 bit: the registered pre-trigger pulse.
REQ-015 SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-016 SHALL have port done, output, 1 bit: single-cycle end-of-sequence strobe.
REQ-017 SHALL have port sent_count, output, CNT_W bits: number of seeds issued in the current or last sequence.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN and DONE; the state register is internal.
REQ-019 SHALL, in IDLE with start=1 and ena=1, latch mode, ntrig, gap and width, clear sent_count, and enter RUN; later input changes SHALL NOT affect the running sequence.
REQ-020 SHALL, in IDLE with start=1, ena=1, mode=0 and ntrig=0, go directly to DONE with no seed issued.
REQ-021 SHALL issue the first seed in the first RUN cycle, then one seed every gap+1 cycles; gap=0 gives a seed every cycle.
REQ-022 SHALL increment sent_count in each seed cycle; in continuous mode it wraps modulo 2^CNT_W.
REQ-023 SHALL, in burst mode, enter DRAIN in the cycle after the ntrig-th seed; exactly ntrig seeds SHALL be issued.
REQ-024 SHALL, in RUN with stop=1 or ena=0, issue no seed in that cycle and enter DRAIN; seeds already in flight SHALL still be delivered.
REQ-025 SHALL pass each seed through a DELAY-stage shift register.
REQ-026 SHALL raise trigger DELAY+1 cycles after the seed cycle and hold it high for max(width,1) consecutive cycles.
REQ-027 SHALL restart the width count when a delayed seed arrives while trigger is already high, so overlapping pulses merge into one extended pulse.
REQ-028 SHALL stay in DRAIN until the delay line is empty and trigger is low, then enter DONE.
REQ-029 SHALL assert done for exactly one cycle while in DONE, then return to IDLE; start is ignored in DONE.
REQ-030 SHALL ignore start outside IDLE, and SHALL ignore stop outside RUN.
REQ-031 SHALL, when start and stop are both 1 in IDLE, arm the sequence; stop then takes effect in the first RUN cycle, before the first seed, so no seed is issued.

Reset
REQ-032 SHALL, with rst=1, on the next edge set state=IDLE, trigger=0, busy=0, done=0, sent_count=0, and clear the delay line and pulse counter; rst overrides all other inputs.
REQ-033 SHALL, on reset mid-sequence or mid-pulse, drop trigger in the next cycle and discard in-flight seeds.

Verification
REQ-034 SHALL be verified by: burst, DELAY=6, ntrig=3, gap=9, width=3, start at cycle 0 -> seeds at cycles 1, 11, 21; trigger high in cycles 8-10, 18-20 and 28-30; done at cycle 32; sent_count=3.
REQ-035 SHALL be verified by: burst, ntrig=0 -> no trigger, busy stays 0, done strobes one cycle after start.
REQ-036 SHALL be verified by: continuous, gap=1, width=4 -> pulses merge, so trigger stays high continuously from cycle 8; stop at cycle 20 -> trigger falls within DELAY+4 cycles, followed by done.
REQ-037 SHALL be verified by: gap=0, width=0, ntrig=5 -> trigger high for exactly 5 consecutive cycles.
REQ-038 SHALL be verified by: rst asserted while trigger=1 -> trigger=0 and busy=0 on the next cycle, with no later pulse.
REQ-039 SHALL be verified by: ena dropped during RUN -> no further seeds, in-flight pulses are completed, and done is asserted once.
